// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_sweep_pkg                                                     |
// | Shared types and constants for the truth-table sweep controller. |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package tt_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIND   = 3'd1,
        DRIVE  = 3'd2,
        REPORT = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam int VEC_W = 4;
    localparam int TT_W  = 16;

    localparam logic [VEC_W-1:0] LAST3 = 4'd7;
    localparam logic [VEC_W-1:0] LAST4 = 4'd15;

    function automatic logic [VEC_W-1:0] last_vec(input logic is4);
        return is4 ? LAST4 : LAST3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_prio_find.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_prio_find                                                     |
// | Lowest set bit of mask at or above start_idx (combinational).    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tt_prio_find #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start_idx,
    output logic          found,
    output logic [IW-1:0] index
);

    logic [N-1:0] w_qual;

    for (genvar gi = 0; gi < N; gi++) begin : g_qual
        assign w_qual[gi] = mask[gi] & (IW'(gi) >= start_idx);
    end

    // Scan downward so the lowest qualifying bit is the last one written.
    always_comb begin
        found = |w_qual;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_qual[i]) begin
                index = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_sweep_ctrl                                                    |
// | Exhaustive truth-table sweeper for small 3/4-input units on a    |
// | shared stimulus bus. Optional macro: GOLDEN_CHECK_EN.            |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_UNITS = 8,
    parameter int SETTLE  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [N_UNITS-1:0]         unit_mask,
    input  logic [N_UNITS-1:0]         unit_is4,
    input  logic                       y_in,
    output logic [$clog2(N_UNITS)-1:0] unit_sel,
    output logic [VEC_W-1:0]           vec,
    output logic                       vec_valid,
    output logic [TT_W-1:0]            tt_word,
    output logic [$clog2(N_UNITS)-1:0] tt_unit,
    output logic                       tt_valid,
    input  logic                       tt_ready,
`ifdef GOLDEN_CHECK_EN
    input  logic [TT_W-1:0]            golden,
    output logic                       mismatch,
    output logic [7:0]                 err_count,
`endif
    output logic                       busy,
    output logic                       done
);

    localparam int IW = $clog2(N_UNITS);
    localparam logic [IW-1:0] c_last_unit = IW'(N_UNITS - 1);
    localparam logic [3:0]    c_settle    = 4'(SETTLE);

    state_t r_state, w_next;

    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_unit_sel;
    logic [VEC_W-1:0] r_vec;
    logic             r_vec_valid;
    logic [TT_W-1:0]  r_tt_word;
    logic [IW-1:0]    r_tt_unit;
    logic             r_tt_valid;
    logic             r_is4;
    logic [3:0]       r_settle;

    logic             w_found;
    logic [IW-1:0]    w_find_idx;
    logic             w_abort;
    logic             w_sample;
    logic             w_last;
    logic             w_handshake;

    tt_prio_find #(
        .N  (N_UNITS),
        .IW (IW)
    ) u_find (
        .mask      (unit_mask),
        .start_idx (r_idx),
        .found     (w_found),
        .index     (w_find_idx)
    );

    assign w_abort     = abort && (r_state != IDLE);
    assign w_sample    = (r_settle == c_settle);
    assign w_last      = (r_vec == last_vec(r_is4));
    assign w_handshake = (r_state == REPORT) && tt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FIND;
            FIND:    w_next = w_found ? DRIVE : FIN;
            DRIVE:   if (w_sample && w_last) w_next = REPORT;
            REPORT:  if (tt_ready) w_next = (r_unit_sel == c_last_unit) ? FIN : FIND;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_unit_sel  <= '0;
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
            r_tt_word   <= '0;
            r_tt_unit   <= '0;
            r_tt_valid  <= 1'b0;
            r_is4       <= 1'b0;
            r_settle    <= '0;
        end else if (w_abort) begin
            r_vec_valid <= 1'b0;
            r_tt_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) r_idx <= '0;
                end
                FIND: begin
                    if (w_found) begin
                        r_unit_sel  <= w_find_idx;
                        r_vec       <= '0;
                        r_tt_word   <= '0;
                        r_vec_valid <= 1'b1;
                        r_is4       <= unit_is4[w_find_idx];
                        r_settle    <= '0;
                    end
                end
                DRIVE: begin
                    if (w_sample) begin
                        r_tt_word[r_vec] <= y_in;
                        r_settle         <= '0;
                        // vec stays at the last vector; only FIND rewinds it
                        if (w_last) begin
                            r_vec_valid <= 1'b0;
                            r_tt_valid  <= 1'b1;
                            r_tt_unit   <= r_unit_sel;
                        end else begin
                            r_vec <= r_vec + 4'd1;
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                REPORT: begin
                    if (tt_ready) begin
                        r_tt_valid <= 1'b0;
                        r_idx      <= r_unit_sel + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GOLDEN_CHECK_EN
    logic [TT_W-1:0] w_tt_mask;
    logic [7:0]      r_err_count;

    assign w_tt_mask = r_is4 ? 16'hFFFF : 16'h00FF;
    assign mismatch  = r_tt_valid && (|((r_tt_word ^ golden) & w_tt_mask));
    assign err_count = r_err_count;

    // Each reported word is counted once, at its accepting handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_err_count <= '0;
        end else if (w_handshake && !w_abort && mismatch && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end
`endif

    assign unit_sel  = r_unit_sel;
    assign vec       = r_vec;
    assign vec_valid = r_vec_valid;
    assign tt_word   = r_tt_word;
    assign tt_unit   = r_tt_unit;
    assign tt_valid  = r_tt_valid;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FIN);

endmodule
`default_nettype wire
